multiply_arbiter: RTL and testbench
===================================

Name: multiply_arbiter

Overview:
- Shares one `multiply` instance between N requesters, each of which presents a complete operand pair.
- Round-robin arbitration; one transaction in flight at a time.
- Serialises the granted pair onto the multiplier's addressed argument stream (addr 0, then addr 1).
- Collects the product and returns it to the owning requester.
- Sits between neuron/accumulator clients and the shared multiplier.

Parameters:
- N, 4, number of requesters (2..16).
- ARGW, 16, operand width; matches multiply ARGW.
- RESW, 2*ARGW, product width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  N  requester i has an operand pair.
- req_ready  out  N  one-hot accept; pair i taken when req_valid[i] & req_ready[i].
- req_data  in  N*2*ARGW  pair i = {op1, op0}; op0 in low ARGW bits.
- rsp_valid  out  N  one-hot; result for requester i.
- rsp_ready  in  N  requester i accepts its result.
- rsp_data  out  RESW  shared result bus; qualify with rsp_valid.
- mul_arg_valid  out  1  argument to multiplier valid.
- mul_arg_ready  in  1  multiplier accepts argument.
- mul_arg_data  out  ARGW  argument value.
- mul_arg_addr  out  1  argument index: 0 = op0, 1 = op1.
- mul_res_valid  in  1  multiplier product valid.
- mul_res_ready  out  1  arbiter accepts product.
- mul_res_data  in  RESW  signed product.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async): state = IDLE, ptr = 0, owner = 0, held operands and result = 0.
  - All outputs 0: req_ready, rsp_valid, mul_arg_valid, mul_res_ready, busy, rsp_data, mul_arg_data, mul_arg_addr.
- Reset mid-transaction abandons it with no response. The multiplier must share the same reset so no stale product remains.
- State IDLE:
  - grant = first i with req_valid[i], searching ptr, ptr+1, … mod N.
  - req_ready = onehot(grant), combinational, only in IDLE; all zero when no request.
  - On accept: latch op0/op1, owner = grant, ptr = (grant+1) mod N, go to ARG0.
- State ARG0: mul_arg_valid = 1, mul_arg_addr = 0, mul_arg_data = op0. On mul_arg_ready, go to ARG1.
- State ARG1: mul_arg_valid = 1, mul_arg_addr = 1, mul_arg_data = op1. On mul_arg_ready, go to WAIT.
- State WAIT: mul_res_ready = 1. On mul_res_valid, latch mul_res_data, go to RESP.
- State RESP:
  - rsp_valid[owner] = 1, rsp_data = latched result.
  - On rsp_ready[owner], go to IDLE.
  - The next grant cannot occur in the same cycle; min 1 IDLE cycle between transactions.
- Valid/ready rules:
  - Outputs are held stable until handshake; valid never drops without ready.
  - Data is don't-care when valid is low; drive 0.
  - Inputs req_data and req_valid are sampled only at acceptance. A requester may drop req_valid while not granted.
- Arithmetic: no arithmetic in arbiter. Product is passed through bit-exact; signedness is owned by multiply.
- Latency: accept to rsp_valid = 3 + multiplier latency + back-pressure cycles (ARG0, ARG1, WAIT each ≥ 1 cycle).
- Fairness: each waiting requester is served within N transactions.
- Pointer wraps N-1 → 0.
- rsp_ready on non-owner ports is ignored.

Test Plan:
- Single requester: req 0 sends op0 = 0x0003, op1 = 0xFFFE (−2) → mul_arg sequence addr0 = 0x0003 then addr1 = 0xFFFE; rsp_valid = 4'b0001, rsp_data = 0xFFFFFFFA. busy is high from accept through response.
- Round-robin: all four req_valid held high, distinct pairs (i+1)*(i+2) → grants in order 0,1,2,3,0. Responses 2, 6, 12, 20 go to the matching one-hot rsp_valid. Pointer wraps after 3.
- Priority rotation: ptr = 2 (after serving 1), requests from 0 and 3 → 3 is granted first, then 0.
- Back-pressure: random stalls on mul_arg_ready and on the owner's rsp_ready (0–5 cycles), 8 random signed pairs → mul_arg and rsp signals stable while stalled; every product equals the signed reference.
- Mid-operation reset: assert rst low during WAIT → all outputs 0 asynchronously and ptr = 0. After release, a new request on port 2 completes correctly and no stale rsp_valid appears.
- Idle: no req_valid for 100 cycles → req_ready = 0, mul_arg_valid = 0, busy = 0 throughout.

Source files
------------

// File: rtl/multiply_arbiter.sv
// Round-robin arbiter sharing one multiplier between N requesters.
// Each granted operand pair is sent as two addressed arguments; the product is routed back to its owner.
module multiply_arbiter #(
    parameter int N    = 4,
    parameter int ARGW = 16,
    parameter int RESW = 2*ARGW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*2*ARGW-1:0]  req_data,
    output logic [N-1:0]         rsp_valid,
    input  logic [N-1:0]         rsp_ready,
    output logic [RESW-1:0]      rsp_data,
    output logic                 mul_arg_valid,
    input  logic                 mul_arg_ready,
    output logic [ARGW-1:0]      mul_arg_data,
    output logic                 mul_arg_addr,
    input  logic                 mul_res_valid,
    output logic                 mul_res_ready,
    input  logic [RESW-1:0]      mul_res_data,
    output logic                 busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG0,
        S_ARG1,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [ARGW-1:0] op1_q;

    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   next_ptr;
    logic            grant_found;
    logic [ARGW-1:0] pair_op0 [N];
    logic [ARGW-1:0] pair_op1 [N];

    // Index addition modulo N; both operands are below N so one correction suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= (PW+1)'(N))
            s = s - (PW+1)'(N);
        return s[PW-1:0];
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign pair_op0[g] = req_data[g*2*ARGW +: ARGW];
        assign pair_op1[g] = req_data[g*2*ARGW + ARGW +: ARGW];
    end

    // Scan from the far end back toward ptr so the candidate closest to ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr, k);
            end
        end
    end

    assign next_ptr  = wrap_add(grant_idx, 1);
    assign req_ready = (state == S_IDLE && grant_found) ? onehot(grant_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            op1_q         <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            mul_arg_valid <= 1'b0;
            mul_arg_addr  <= 1'b0;
            mul_arg_data  <= '0;
            mul_res_ready <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // op0 goes straight to the argument register; only op1 needs holding.
                    if (grant_found) begin
                        state         <= S_ARG0;
                        owner         <= grant_idx;
                        ptr           <= next_ptr;
                        op1_q         <= pair_op1[grant_idx];
                        mul_arg_valid <= 1'b1;
                        mul_arg_addr  <= 1'b0;
                        mul_arg_data  <= pair_op0[grant_idx];
                        busy          <= 1'b1;
                    end
                end
                S_ARG0: begin
                    if (mul_arg_ready) begin
                        state        <= S_ARG1;
                        mul_arg_addr <= 1'b1;
                        mul_arg_data <= op1_q;
                    end
                end
                S_ARG1: begin
                    if (mul_arg_ready) begin
                        state         <= S_WAIT;
                        mul_arg_valid <= 1'b0;
                        mul_arg_addr  <= 1'b0;
                        mul_arg_data  <= '0;
                        mul_res_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mul_res_valid) begin
                        state         <= S_RESP;
                        mul_res_ready <= 1'b0;
                        rsp_valid     <= onehot(owner);
                        rsp_data      <= mul_res_data;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        state     <= S_IDLE;
                        rsp_valid <= '0;
                        rsp_data  <= '0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter: vector table plus a cycle-level scoreboard and multiplier model.
module tb_multiply_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_data;
    logic         mul_arg_valid;
    logic         mul_arg_ready;
    logic [15:0]  mul_arg_data;
    logic         mul_arg_addr;
    logic         mul_res_valid;
    logic         mul_res_ready;
    logic [31:0]  mul_res_data;
    logic         busy;

    multiply_arbiter #(.N(4), .ARGW(16), .RESW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_arg_valid(mul_arg_valid), .mul_arg_ready(mul_arg_ready),
        .mul_arg_data(mul_arg_data), .mul_arg_addr(mul_arg_addr),
        .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready),
        .mul_res_data(mul_res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op0;
        logic [31:0] exp;
    } item_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        int          grp;
        int          port;
        logic [15:0] op0;
        logic [15:0] op1;
        logic [31:0] exp;
    } vec_t;

    item_t       pend [4][$];
    sb_t         sb_q [$];
    logic [16:0] arg_q [$];
    int          grant_log [$];
    vec_t        vecs [9];

    int  n_pass, n_total;
    int  phase, tb_ptr;
    bit  stall_en;
    int  arg_cnt, rsp_cnt;
    bit  mpend;
    int  mcnt, mlat_lo, mlat_hi;
    logic [15:0] ma0;
    logic [31:0] mprod;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int pend_count();
        int c = 0;
        for (int p = 0; p < 4; p++) c += pend[p].size();
        return c;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_arg_valid"}, mul_arg_valid, 0);
        check({tag, "_res_ready"}, mul_res_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_arg_data"}, mul_arg_data, 0);
        check({tag, "_arg_addr"}, mul_arg_addr, 0);
    endtask

    task automatic clear_models();
        for (int p = 0; p < 4; p++) pend[p].delete();
        sb_q.delete();
        arg_q.delete();
        phase     = 0;
        tb_ptr    = 0;
        mpend     = 1'b0;
        mcnt      = 0;
        arg_cnt   = 0;
        rsp_cnt   = 0;
        req_valid = '0;
        mul_res_valid = 1'b0;
    endtask

    // One clock: drive at negedge, check and advance the model just before the posedge.
    task automatic cycle();
        int g;
        bit found;
        item_t it;
        logic signed [15:0] a, b;
        logic signed [31:0] ps;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (pend[p].size() > 0) begin
                req_valid[p] = 1'b1;
                req_data[p*32 +: 32] = {pend[p][0].op1, pend[p][0].op0};
            end else begin
                req_valid[p] = 1'b0;
                req_data[p*32 +: 32] = $urandom;
            end
        end
        if (mpend && mcnt == 0) begin
            mul_res_valid = 1'b1;
            mul_res_data  = mprod;
        end else begin
            mul_res_valid = 1'b0;
            mul_res_data  = $urandom;
            if (mpend) mcnt--;
        end
        if (mul_arg_valid && arg_cnt > 0) begin
            mul_arg_ready = 1'b0;
            arg_cnt--;
        end else
            mul_arg_ready = 1'b1;
        if (rsp_valid != 0 && rsp_cnt > 0) begin
            rsp_ready = ~rsp_valid;
            rsp_cnt--;
        end else
            rsp_ready = 4'hF;
        #1;
        found = 1'b0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (tb_ptr + k) % 4;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                g = c;
            end
        end
        check("req_ready", req_ready, (phase == 0 && found) ? (64'd1 << g) : 64'd0);
        check("busy", busy, phase != 0);
        check("arg_valid", mul_arg_valid, phase == 1 || phase == 2);
        check("res_ready", mul_res_ready, phase == 3);
        if (phase == 1 || phase == 2)
            check("arg", {mul_arg_addr, mul_arg_data}, arg_q[0]);
        else
            check("arg_idle", {mul_arg_addr, mul_arg_data}, 0);
        if (phase == 4) begin
            check("rsp_valid", rsp_valid, 64'd1 << sb_q[0].port);
            check("rsp_data", rsp_data, sb_q[0].exp);
        end else begin
            check("rsp_valid_idle", rsp_valid, 0);
            check("rsp_data_idle", rsp_data, 0);
        end
        case (phase)
            0: if (found) begin
                it = pend[g].pop_front();
                sb_q.push_back({2'(g), it.exp});
                arg_q.push_back({1'b0, it.op0});
                arg_q.push_back({1'b1, it.op1});
                tb_ptr = (g + 1) % 4;
                grant_log.push_back(g);
                arg_cnt = stall_en ? int'($urandom_range(5, 0)) : 0;
                phase = 1;
            end
            1: if (mul_arg_ready) begin
                ma0 = mul_arg_data;
                void'(arg_q.pop_front());
                arg_cnt = stall_en ? int'($urandom_range(5, 0)) : 0;
                phase = 2;
            end
            2: if (mul_arg_ready) begin
                a = ma0;
                b = mul_arg_data;
                ps = a * b;
                mprod = ps;
                void'(arg_q.pop_front());
                mpend = 1'b1;
                mcnt = int'($urandom_range(mlat_hi, mlat_lo));
                phase = 3;
            end
            3: if (mul_res_valid) begin
                mpend = 1'b0;
                rsp_cnt = stall_en ? int'($urandom_range(5, 0)) : 0;
                phase = 4;
            end
            4: if (rsp_ready[sb_q[0].port]) begin
                void'(sb_q.pop_front());
                phase = 0;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((phase != 0 || pend_count() != 0) && n < budget);
        check("drain_phase", phase, 0);
        check("drain_pend", pend_count(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("rst");
        clear_models();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int j, cnt;
        logic signed [15:0] sa, sb;
        logic signed [31:0] sp;
        n_pass = 0; n_total = 0;
        stall_en = 1'b0; mlat_lo = 0; mlat_hi = 0;
        rst = 1'b0;
        req_data = '0; rsp_ready = '0; mul_arg_ready = 1'b0; mul_res_data = '0;
        clear_models();

        vecs[0] = '{0, 0, 16'h0003, 16'hFFFE, 32'hFFFFFFFA};
        vecs[1] = '{1, 0, 16'h0001, 16'h0002, 32'd2};
        vecs[2] = '{1, 1, 16'h0002, 16'h0003, 32'd6};
        vecs[3] = '{1, 2, 16'h0003, 16'h0004, 32'd12};
        vecs[4] = '{1, 3, 16'h0004, 16'h0005, 32'd20};
        vecs[5] = '{1, 0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[6] = '{2, 1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1};
        vecs[7] = '{3, 3, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[8] = '{3, 0, 16'h0000, 16'h1234, 32'h00000000};

        repeat (3) @(negedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Vector groups, each listed in its required grant order
        for (int grp = 0; grp < 4; grp++) begin
            if (grp == 1) do_reset();
            grant_log.delete();
            cnt = 0;
            for (int v = 0; v < 9; v++)
                if (vecs[v].grp == grp) begin
                    pend[vecs[v].port].push_back({vecs[v].op1, vecs[v].op0, vecs[v].exp});
                    cnt++;
                end
            run_until_idle(300);
            check("order_len", grant_log.size(), cnt);
            j = 0;
            for (int v = 0; v < 9; v++)
                if (vecs[v].grp == grp) begin
                    if (j < grant_log.size()) check("order", grant_log[j], vecs[v].port);
                    j++;
                end
        end

        // Back-pressure with random signed operands
        stall_en = 1'b1; mlat_lo = 0; mlat_hi = 3;
        for (int i = 0; i < 8; i++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            sp = sa * sb;
            pend[$urandom_range(3, 0)].push_back({sb, sa, sp});
        end
        run_until_idle(2000);
        stall_en = 1'b0; mlat_lo = 0; mlat_hi = 0;

        // Reset while the multiplier result is outstanding
        mlat_lo = 30; mlat_hi = 30;
        pend[1].push_back({16'h0006, 16'h0007, 32'd42});
        j = 0;
        while (phase != 3 && j < 50) begin
            cycle();
            j++;
        end
        check("reach_wait", phase, 3);
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check_zero("async");
        clear_models();
        mlat_lo = 0; mlat_hi = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        grant_log.delete();
        pend[3].push_back({16'hFFFF, 16'hFFFF, 32'd1});
        pend[1].push_back({16'h0010, 16'h0010, 32'd256});
        run_until_idle(300);
        check("post_rst_len", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("post_rst_first", grant_log[0], 1);
            check("post_rst_second", grant_log[1], 3);
        end
        pend[2].push_back({16'hFFF9, 16'h0009, 32'hFFFFFFC1});
        run_until_idle(300);

        // Quiet period
        repeat (100) begin
            cycle();
            check("idle_req_ready", req_ready, 0);
            check("idle_arg_valid", mul_arg_valid, 0);
            check("idle_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
